// File: rtl/vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl
//   Scan/timing generator for the VGA output path. Free-running horizontal and
//   vertical counters produce the pixel address sent to the pixel-data driver.
//   The returned pixel is captured and presented to the DAC together with
//   hsync/vsync/de, all delayed so they line up with the driver's latency.
//
// Ports
//   vga_clk      in   1   pixel clock
//   rst_n        in   1   asynchronous reset, active-low
//   rgb_data     in   16  RGB565 pixel returned by the data driver
//   addr_h       out  12  active column 1..H_ACTIVE, 0 outside active window
//   addr_v       out  12  active row 1..V_ACTIVE, 0 outside active window
//   frame_start  out  1   one-cycle pulse when the scan wraps to (0,0)
//   hsync        out  1   horizontal sync, aligned to rgb
//   vsync        out  1   vertical sync, aligned to rgb
//   de           out  1   data enable, aligned to rgb
//   rgb          out  16  pixel to DAC, 0 whenever de=0
// ---------------------------------------------------------------------------
module vga_timing_ctrl #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned DATA_LAT = 0
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic [15:0] rgb_data,
    output logic [11:0] addr_h,
    output logic [11:0] addr_v,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [15:0] rgb
);

    // Axis boundaries as 12-bit constants; *_END values are exclusive.
    localparam logic [11:0] C_H_SYNC_END = 12'(H_SYNC);
    localparam logic [11:0] C_H_ACT_BEG  = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] C_H_ACT_END  = 12'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [11:0] C_H_LAST     = 12'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
    localparam logic [11:0] C_V_SYNC_END = 12'(V_SYNC);
    localparam logic [11:0] C_V_ACT_BEG  = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] C_V_ACT_END  = 12'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [11:0] C_V_LAST     = 12'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);

    localparam logic C_SYNC_ON  = SYNC_POL;
    localparam logic C_SYNC_OFF = ~SYNC_POL;

    // Phase order along each axis, starting from count 0.
    typedef enum logic [1:0] {
        PH_SYNC,
        PH_BACK,
        PH_ACTIVE,
        PH_FRONT
    } phase_e;

    function automatic phase_e axis_phase(
        input logic [11:0] cnt,
        input logic [11:0] sync_end,
        input logic [11:0] act_beg,
        input logic [11:0] act_end
    );
        phase_e ph;
        if (cnt < sync_end) begin
            ph = PH_SYNC;
        end else if (cnt < act_beg) begin
            ph = PH_BACK;
        end else if (cnt < act_end) begin
            ph = PH_ACTIVE;
        end else begin
            ph = PH_FRONT;
        end
        return ph;
    endfunction

    // Scan counters and their next values
    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    logic [11:0] w_h_next;
    logic [11:0] w_v_next;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_frame_wrap;

    // Phase decode of the current and next count
    phase_e      w_h_ph;
    phase_e      w_v_ph;
    phase_e      w_h_ph_nx;
    phase_e      w_v_ph_nx;
    logic        w_win;
    logic        w_win_nx;
    logic        w_hs_raw;
    logic        w_vs_raw;
    logic [11:0] w_addr_h_nx;
    logic [11:0] w_addr_v_nx;

    // Registered address / frame pulse
    logic [11:0] r_addr_h;
    logic [11:0] r_addr_v;
    logic        r_frame_start;

    // Sync/de delay lines. The *_chain vectors place the raw value at bit 0 and
    // stage i at bit i+1, so chain[k] is the raw signal delayed by k cycles for
    // any DATA_LAT, including 0, without a negative index.
    logic [DATA_LAT:0]   r_hs_dly;
    logic [DATA_LAT:0]   r_vs_dly;
    logic [DATA_LAT:0]   r_de_dly;
    logic [DATA_LAT+1:0] w_hs_chain;
    logic [DATA_LAT+1:0] w_vs_chain;
    logic [DATA_LAT+1:0] w_de_chain;
    logic [15:0]         r_rgb;

    // -----------------------------------------------------------------------
    // Counter next-state
    // -----------------------------------------------------------------------
    always_comb begin
        w_h_wrap     = (r_h_cnt == C_H_LAST);
        w_v_wrap     = (r_v_cnt == C_V_LAST);
        w_frame_wrap = w_h_wrap && w_v_wrap;
        w_h_next     = w_h_wrap ? '0 : r_h_cnt + 12'd1;
        w_v_next     = r_v_cnt;
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? '0 : r_v_cnt + 12'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Phase decode: current count drives raw sync/de, next count drives the
    // registered address so it reflects the count loaded on the same edge.
    // -----------------------------------------------------------------------
    always_comb begin
        w_h_ph    = axis_phase(r_h_cnt,  C_H_SYNC_END, C_H_ACT_BEG, C_H_ACT_END);
        w_v_ph    = axis_phase(r_v_cnt,  C_V_SYNC_END, C_V_ACT_BEG, C_V_ACT_END);
        w_h_ph_nx = axis_phase(w_h_next, C_H_SYNC_END, C_H_ACT_BEG, C_H_ACT_END);
        w_v_ph_nx = axis_phase(w_v_next, C_V_SYNC_END, C_V_ACT_BEG, C_V_ACT_END);

        w_win    = (w_h_ph == PH_ACTIVE) && (w_v_ph == PH_ACTIVE);
        w_win_nx = (w_h_ph_nx == PH_ACTIVE) && (w_v_ph_nx == PH_ACTIVE);

        w_hs_raw = (w_h_ph == PH_SYNC) ? C_SYNC_ON : C_SYNC_OFF;
        w_vs_raw = (w_v_ph == PH_SYNC) ? C_SYNC_ON : C_SYNC_OFF;

        // Both addresses are 0 unless both axes are inside the window.
        w_addr_h_nx = '0;
        w_addr_v_nx = '0;
        if (w_win_nx) begin
            w_addr_h_nx = w_h_next - C_H_ACT_BEG + 12'd1;
            w_addr_v_nx = w_v_next - C_V_ACT_BEG + 12'd1;
        end
    end

    always_comb begin
        w_hs_chain = {r_hs_dly, w_hs_raw};
        w_vs_chain = {r_vs_dly, w_vs_raw};
        w_de_chain = {r_de_dly, w_win};
    end

    // -----------------------------------------------------------------------
    // Counters, address and frame pulse
    // -----------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_addr_h      <= '0;
            r_addr_v      <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_h_cnt       <= w_h_next;
            r_v_cnt       <= w_v_next;
            r_addr_h      <= w_addr_h_nx;
            r_addr_v      <= w_addr_v_nx;
            // Counters only reach (0,0) via a full-frame wrap after reset,
            // since the first edge moves them off (0,0).
            r_frame_start <= w_frame_wrap;
        end
    end

    // -----------------------------------------------------------------------
    // Output alignment: sync/de go through DATA_LAT+1 stages; the pixel is
    // sampled DATA_LAT cycles after its address, gated by that address's de.
    // -----------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_dly <= {(DATA_LAT+1){C_SYNC_OFF}};
            r_vs_dly <= {(DATA_LAT+1){C_SYNC_OFF}};
            r_de_dly <= '0;
            r_rgb    <= '0;
        end else begin
            r_hs_dly <= w_hs_chain[DATA_LAT:0];
            r_vs_dly <= w_vs_chain[DATA_LAT:0];
            r_de_dly <= w_de_chain[DATA_LAT:0];
            r_rgb    <= w_de_chain[DATA_LAT] ? rgb_data : '0;
        end
    end

    assign addr_h      = r_addr_h;
    assign addr_v      = r_addr_v;
    assign frame_start = r_frame_start;
    assign hsync       = r_hs_dly[DATA_LAT];
    assign vsync       = r_vs_dly[DATA_LAT];
    assign de          = r_de_dly[DATA_LAT];
    assign rgb         = r_rgb;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_ctrl
//   Four instances share clock and reset: three with a reduced raster and
//   latencies 0/1/3 (one with active-high sync) fed from a random image,
//   plus one with default timing fed by the {addr_v[3:0],addr_h} loopback.
//   Outputs are compared every cycle against an arithmetic raster model.
// ---------------------------------------------------------------------------
module tb_vga_timing_ctrl;

    localparam int unsigned SH_SYNC = 4;
    localparam int unsigned SH_BACK = 3;
    localparam int unsigned SH_ACT  = 10;
    localparam int unsigned SH_FRNT = 2;
    localparam int unsigned SV_SYNC = 2;
    localparam int unsigned SV_BACK = 3;
    localparam int unsigned SV_ACT  = 6;
    localparam int unsigned SV_FRNT = 2;

    typedef struct packed {
        logic [11:0] ah;
        logic [11:0] av;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        de;
        logic [15:0] rgb;
    } out_t;

    typedef struct {
        int   hs, hb, ha, hf;
        int   vs, vb, va, vf;
        int   lat;
        logic pol;
        int   mode;   // 0: random image, 1: {addr_v[3:0],addr_h}
    } cfg_t;

    typedef struct {
        int   n;
        out_t exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n;
    int   tests;
    int   fails;

    logic [15:0] img [0:15][0:15];
    cfg_t        ca, cb, cc, cd;

    logic [15:0] rgbd_a, rgbd_b, rgbd_c, rgbd_d;
    logic [11:0] ah_a, av_a, ah_b, av_b, ah_c, av_c, ah_d, av_d;
    logic        fs_a, hs_a, vs_a, de_a;
    logic        fs_b, hs_b, vs_b, de_b;
    logic        fs_c, hs_c, vs_c, de_c;
    logic        fs_d, hs_d, vs_d, de_d;
    logic [15:0] rgb_a, rgb_b, rgb_c, rgb_d;
    logic [15:0] pipe_b;
    logic [15:0] pipe_c [0:2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pixel drivers with the matching return latency
    always_comb rgbd_a = img[av_a[3:0]][ah_a[3:0]];
    always_ff @(posedge clk) pipe_b <= img[av_b[3:0]][ah_b[3:0]];
    assign rgbd_b = pipe_b;
    always_ff @(posedge clk) begin
        pipe_c[0] <= img[av_c[3:0]][ah_c[3:0]];
        pipe_c[1] <= pipe_c[0];
        pipe_c[2] <= pipe_c[1];
    end
    assign rgbd_c = pipe_c[2];
    assign rgbd_d = {av_d[3:0], ah_d};

    vga_timing_ctrl #(
        .H_SYNC(SH_SYNC), .H_BACK(SH_BACK), .H_ACTIVE(SH_ACT), .H_FRONT(SH_FRNT),
        .V_SYNC(SV_SYNC), .V_BACK(SV_BACK), .V_ACTIVE(SV_ACT), .V_FRONT(SV_FRNT),
        .SYNC_POL(1'b0), .DATA_LAT(0)
    ) u_a (
        .vga_clk(clk), .rst_n(rst_n), .rgb_data(rgbd_a),
        .addr_h(ah_a), .addr_v(av_a), .frame_start(fs_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .rgb(rgb_a)
    );

    vga_timing_ctrl #(
        .H_SYNC(SH_SYNC), .H_BACK(SH_BACK), .H_ACTIVE(SH_ACT), .H_FRONT(SH_FRNT),
        .V_SYNC(SV_SYNC), .V_BACK(SV_BACK), .V_ACTIVE(SV_ACT), .V_FRONT(SV_FRNT),
        .SYNC_POL(1'b0), .DATA_LAT(1)
    ) u_b (
        .vga_clk(clk), .rst_n(rst_n), .rgb_data(rgbd_b),
        .addr_h(ah_b), .addr_v(av_b), .frame_start(fs_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .rgb(rgb_b)
    );

    vga_timing_ctrl #(
        .H_SYNC(SH_SYNC), .H_BACK(SH_BACK), .H_ACTIVE(SH_ACT), .H_FRONT(SH_FRNT),
        .V_SYNC(SV_SYNC), .V_BACK(SV_BACK), .V_ACTIVE(SV_ACT), .V_FRONT(SV_FRNT),
        .SYNC_POL(1'b1), .DATA_LAT(3)
    ) u_c (
        .vga_clk(clk), .rst_n(rst_n), .rgb_data(rgbd_c),
        .addr_h(ah_c), .addr_v(av_c), .frame_start(fs_c),
        .hsync(hs_c), .vsync(vs_c), .de(de_c), .rgb(rgb_c)
    );

    vga_timing_ctrl u_d (
        .vga_clk(clk), .rst_n(rst_n), .rgb_data(rgbd_d),
        .addr_h(ah_d), .addr_v(av_d), .frame_start(fs_d),
        .hsync(hs_d), .vsync(vs_d), .de(de_d), .rgb(rgb_d)
    );

    // Reference raster: n = clock edges since reset release.
    function automatic bit in_win(input cfg_t c, input int h, input int v);
        return (h >= c.hs + c.hb) && (h < c.hs + c.hb + c.ha) &&
               (v >= c.vs + c.vb) && (v < c.vs + c.vb + c.va);
    endfunction

    function automatic out_t model(input cfg_t c, input int cyc);
        int   ht, vt, frame, pos, h, v, m, hm, vm, ax, ay;
        logic [11:0] ax12, ay12;
        out_t o;
        ht    = c.hs + c.hb + c.ha + c.hf;
        vt    = c.vs + c.vb + c.va + c.vf;
        frame = ht * vt;
        pos   = cyc % frame;
        h     = pos % ht;
        v     = pos / ht;
        o     = '0;
        if (in_win(c, h, v)) begin
            o.ah = 12'(h - c.hs - c.hb + 1);
            o.av = 12'(v - c.vs - c.vb + 1);
        end
        o.fs = (cyc > 0) && (pos == 0);
        m    = cyc - c.lat - 1;
        if (m < 0) begin
            o.hs = ~c.pol;
            o.vs = ~c.pol;
        end else begin
            hm   = (m % frame) % ht;
            vm   = (m % frame) / ht;
            o.hs = (hm < c.hs) ? c.pol : ~c.pol;
            o.vs = (vm < c.vs) ? c.pol : ~c.pol;
            o.de = in_win(c, hm, vm);
            if (o.de) begin
                ax   = hm - c.hs - c.hb + 1;
                ay   = vm - c.vs - c.vb + 1;
                ax12 = 12'(ax);
                ay12 = 12'(ay);
                o.rgb = (c.mode == 1) ? {ay12[3:0], ax12} : img[ay][ax];
            end
        end
        return o;
    endfunction

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
    endtask

    task automatic note_fail();
        fails++;
        if (fails >= 40) begin
            summary();
            $finish;
        end
    endtask

    task automatic check(input string name, input out_t got, input out_t exp);
        tests++;
        if (got !== exp) begin
            $display("FAIL %s n=%0d got ah=%0d av=%0d fs=%b hs=%b vs=%b de=%b rgb=%h required ah=%0d av=%0d fs=%b hs=%b vs=%b de=%b rgb=%h",
                     name, n, got.ah, got.av, got.fs, got.hs, got.vs, got.de, got.rgb,
                     exp.ah, exp.av, exp.fs, exp.hs, exp.vs, exp.de, exp.rgb);
            note_fail();
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            $display("FAIL %s got %0d required %0d", name, got, exp);
            note_fail();
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_a"}, out_t'{ah_a, av_a, fs_a, hs_a, vs_a, de_a, rgb_a}, model(ca, n));
        check({tag, "_b"}, out_t'{ah_b, av_b, fs_b, hs_b, vs_b, de_b, rgb_b}, model(cb, n));
        check({tag, "_c"}, out_t'{ah_c, av_c, fs_c, hs_c, vs_c, de_c, rgb_c}, model(cc, n));
        check({tag, "_d"}, out_t'{ah_d, av_d, fs_d, hs_d, vs_d, de_d, rgb_d}, model(cd, n));
    endtask

    // One clock: count the edge if out of reset, then sample on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) n++;
        @(negedge clk);
        check_all("cyc");
    endtask

    // Called at a falling edge: asserts reset between edges, checks the
    // outputs before any clock edge, holds for `hold` cycles, releases.
    task automatic pulse_reset(input int hold);
        #2 rst_n = 1'b0;
        n = 0;
        #1 check_all("rst_async");
        for (int k = 0; k < hold; k++) step();
        #1 rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input int cyc, input int ah, input int av,
                                input logic hs, input logic vs, input logic de,
                                input logic [15:0] rgb);
        vec_t t;
        t.n       = cyc;
        t.exp.ah  = 12'(ah);
        t.exp.av  = 12'(av);
        t.exp.fs  = 1'b0;
        t.exp.hs  = hs;
        t.exp.vs  = vs;
        t.exp.de  = de;
        t.exp.rgb = rgb;
        return t;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t tbl [13];
        int   fs_at [$];
        int   frame_a;

        // Default-timing waypoints (DATA_LAT=0, active-low sync)
        tbl[0]  = mk(0,     0,   0, 1'b1, 1'b1, 1'b0, 16'h0000);
        tbl[1]  = mk(1,     0,   0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tbl[2]  = mk(96,    0,   0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tbl[3]  = mk(97,    0,   0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tbl[4]  = mk(1600,  0,   0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tbl[5]  = mk(1601,  0,   0, 1'b0, 1'b1, 1'b0, 16'h0000);
        tbl[6]  = mk(28144, 1,   1, 1'b1, 1'b1, 1'b0, 16'h0000);
        tbl[7]  = mk(28145, 2,   1, 1'b1, 1'b1, 1'b1, 16'h1001);
        tbl[8]  = mk(28783, 640, 1, 1'b1, 1'b1, 1'b1, 16'h127F);
        tbl[9]  = mk(28784, 0,   0, 1'b1, 1'b1, 1'b1, 16'h1280);
        tbl[10] = mk(28785, 0,   0, 1'b1, 1'b1, 1'b0, 16'h0000);
        tbl[11] = mk(28800, 0,   0, 1'b1, 1'b1, 1'b0, 16'h0000);
        tbl[12] = mk(28801, 0,   0, 1'b0, 1'b1, 1'b0, 16'h0000);

        tests = 0;
        fails = 0;
        n     = 0;
        rst_n = 1'b0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                img[y][x] = 16'($urandom);

        ca = '{hs: SH_SYNC, hb: SH_BACK, ha: SH_ACT, hf: SH_FRNT,
               vs: SV_SYNC, vb: SV_BACK, va: SV_ACT, vf: SV_FRNT,
               lat: 0, pol: 1'b0, mode: 0};
        cb = ca;
        cb.lat = 1;
        cc = ca;
        cc.lat = 3;
        cc.pol = 1'b1;
        cd = '{hs: 96, hb: 48, ha: 640, hf: 16, vs: 2, vb: 33, va: 480, vf: 10,
               lat: 0, pol: 1'b0, mode: 1};
        frame_a = (SH_SYNC + SH_BACK + SH_ACT + SH_FRNT) *
                  (SV_SYNC + SV_BACK + SV_ACT + SV_FRNT);

        // Held in reset across a few edges
        @(negedge clk);
        check_all("reset");
        step();
        step();
        #2 rst_n = 1'b1;

        // Table vectors on the default-timing instance
        for (int i = 0; i < 13; i++) begin
            while (n < tbl[i].n) step();
            check($sformatf("vec%0d", i),
                  out_t'{ah_d, av_d, fs_d, hs_d, vs_d, de_d, rgb_d}, tbl[i].exp);
        end

        // Async reset in the middle of an active line (small raster line 8, h 12)
        pulse_reset(1);
        while (n < 164) step();
        pulse_reset(2);

        // frame_start spacing and width over three frames after release
        for (int k = 0; k < 3 * frame_a + 15; k++) begin
            step();
            if (fs_a) fs_at.push_back(n);
        end
        check_int("fs_count", fs_at.size(), 3);
        for (int i = 0; i < fs_at.size() && i < 3; i++)
            check_int($sformatf("fs_pos%0d", i), fs_at[i], frame_a * (i + 1));

        // Random run lengths with random resets in between
        for (int it = 0; it < 25; it++) begin
            int len;
            len = int'($urandom_range(400, 20));
            for (int k = 0; k < len; k++) step();
            pulse_reset(int'($urandom_range(3, 0)));
        end
        for (int k = 0; k < 300; k++) step();

        summary();
        $finish;
    end

endmodule
